// File: rtl/btb_offset_enc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : btb_offset_enc_if                                           |
// | Brief  : Lookup/update bundle between the CPU pipeline and the BTB.  |
// |          master = pipeline (IF/ID stages), slave = btb_offset_enc.   |
// |          Lookup : if_pc -> pred_hit, pred_taken, pred_dest           |
// |          Update : upd_en, upd_pc, upd_taken, upd_dest -> upd_reject  |
// |          btb_flush exists only when BTB_FLUSH_EN is defined.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface btb_offset_enc_if;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_dest;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_dest;
  logic        upd_reject;
`ifdef BTB_FLUSH_EN
  logic        btb_flush;

  modport master (
    output if_pc, upd_en, upd_pc, upd_taken, upd_dest, btb_flush,
    input  pred_hit, pred_taken, pred_dest, upd_reject
  );
  modport slave (
    input  if_pc, upd_en, upd_pc, upd_taken, upd_dest, btb_flush,
    output pred_hit, pred_taken, pred_dest, upd_reject
  );
`else
  modport master (
    output if_pc, upd_en, upd_pc, upd_taken, upd_dest,
    input  pred_hit, pred_taken, pred_dest, upd_reject
  );
  modport slave (
    input  if_pc, upd_en, upd_pc, upd_taken, upd_dest,
    output pred_hit, pred_taken, pred_dest, upd_reject
  );
`endif
endinterface
`default_nettype wire

// File: rtl/btb_offset_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : btb_offset_enc                                              |
// | Brief  : Direct-mapped branch target buffer. Targets are stored as   |
// |          16-bit word offsets relative to PC+4 plus a 2-bit direction |
// |          counter; the IF lookup rebuilds the full target.            |
// | Ports  : clk  - clock, all state changes on rising edge              |
// |          rst  - asynchronous active-high reset                       |
// |          bus  - btb_offset_enc_if.slave (lookup + update paths)      |
// | Macro  : BTB_FLUSH_EN - adds bus.btb_flush, a synchronous clear of   |
// |          all valid bits (counters kept).                             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module btb_offset_enc #(
  parameter int ENTRIES = 16,          // power of two
  parameter int IDX_W   = 4            // log2(ENTRIES)
) (
  input  wire              clk,
  input  wire              rst,
  btb_offset_enc_if.slave  bus
);

  localparam int c_TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr [ENTRIES];
  logic [c_TAG_W-1:0] r_tag [ENTRIES];
  logic [15:0]        r_off [ENTRIES];
  logic               r_reject;

  // ---------------- lookup (combinational) ----------------
  logic [IDX_W-1:0]   w_if_idx;
  logic [c_TAG_W-1:0] w_if_tag;
  logic               w_if_hit;
  logic [15:0]        w_if_off;

  assign w_if_idx = bus.if_pc[IDX_W+1:2];
  assign w_if_tag = bus.if_pc[31:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_if_off = r_off[w_if_idx];

  assign bus.pred_hit   = w_if_hit;
  assign bus.pred_taken = w_if_hit && r_ctr[w_if_idx][1];
  assign bus.pred_dest  = w_if_hit
                        ? bus.if_pc + 32'd4 + {{14{w_if_off[15]}}, w_if_off, 2'b00}
                        : 32'd0;
  assign bus.upd_reject = r_reject;

  // ---------------- update encoding ----------------
  logic [IDX_W-1:0]   w_upd_idx;
  logic [c_TAG_W-1:0] w_upd_tag;
  logic [31:0]        w_diff;
  logic               w_enc;
  logic               w_upd_hit;

  assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
  assign w_upd_tag = bus.upd_pc[31:IDX_W+2];
  assign w_diff    = bus.upd_dest - (bus.upd_pc + 32'd4);
  // Offset fits in 16 signed words: word aligned and bits 31:17 a pure sign extension.
  assign w_enc     = (w_diff[1:0] == 2'b00) && (w_diff[31:17] == {15{w_diff[17]}});
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_reject <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= 2'b01;
        r_tag[i] <= '0;
        r_off[i] <= '0;
      end
    end else begin
      r_reject <= bus.upd_en && !w_enc;
`ifdef BTB_FLUSH_EN
      if (bus.btb_flush) begin
        r_valid <= '0;
      end else
`endif
      if (bus.upd_en) begin
        if (w_enc) begin
          if (w_upd_hit) begin
            if (bus.upd_taken) begin
              if (r_ctr[w_upd_idx] != 2'b11) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'b01;
              r_off[w_upd_idx] <= w_diff[17:2];
            end else if (r_ctr[w_upd_idx] != 2'b00) begin
              r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'b01;
            end
          end else if (bus.upd_taken) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_tag[w_upd_idx]   <= w_upd_tag;
            r_off[w_upd_idx]   <= w_diff[17:2];
            r_ctr[w_upd_idx]   <= 2'b10;
          end
        end else if (w_upd_hit && bus.upd_taken) begin
          // Branch now goes somewhere the entry cannot represent: stale target.
          r_valid[w_upd_idx] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_offset_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_btb_offset_enc                                           |
// | Brief  : Self-checking bench for btb_offset_enc. Expected values are |
// |          queued when stimulus is driven and popped when the DUT      |
// |          output is sampled.                                          |
// | Macro  : BTB_FLUSH_EN - also exercises the flush port.               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_btb_offset_enc;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  btb_offset_enc_if bus();

  btb_offset_enc #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk_val("sb_empty", obs, 32'hDEAD_BEEF);
    end else begin
      e = sb_q.pop_front();
      chk_val(e.tag, obs, e.exp);
    end
  endtask

  // Queue expected lookup results, then sample outputs away from the edge.
  task automatic push_lookup(input string tag, input logic hit, input logic tkn, input logic [31:0] dest);
    sb_push({tag, "_hit"}, {31'd0, hit});
    sb_push({tag, "_tkn"}, {31'd0, tkn});
    sb_push({tag, "_dst"}, dest);
  endtask

  task automatic pop_lookup();
    sb_pop({31'd0, bus.pred_hit});
    sb_pop({31'd0, bus.pred_taken});
    sb_pop(bus.pred_dest);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tkn, input logic [31:0] dest);
    @(negedge clk);
    bus.if_pc = pc;
    push_lookup(tag, hit, tkn, dest);
    #2;
    pop_lookup();
  endtask

  task automatic update(input string tag, input logic [31:0] pc, input logic [31:0] dest,
                        input logic tkn, input logic rej);
    @(negedge clk);
    bus.upd_en    = 1'b1;
    bus.upd_pc    = pc;
    bus.upd_dest  = dest;
    bus.upd_taken = tkn;
    sb_push({tag, "_rej"}, {31'd0, rej});
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
    sb_pop({31'd0, bus.upd_reject});
  endtask

  task automatic idle_rej_clear(input string tag);
    @(negedge clk);
    sb_push({tag, "_rej_clr"}, 32'd0);
    @(posedge clk);
    #1;
    sb_pop({31'd0, bus.upd_reject});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0x00000000, want 0x00000001");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.if_pc      = 32'h10;
    bus.upd_en     = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_dest   = '0;
`ifdef BTB_FLUSH_EN
    bus.btb_flush  = 1'b0;
`endif
    #12;
    push_lookup("rst", 1'b0, 1'b0, 32'd0);
    pop_lookup();
    chk_val("rst_rej", {31'd0, bus.upd_reject}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Forward allocation, off = 7
    update("alloc_fwd", 32'h10, 32'h30, 1'b1, 1'b0);
    lookup("fwd", 32'h10, 1'b1, 1'b1, 32'h30);

    // Backward target, off = 0xFFFB
    update("alloc_bwd", 32'h100, 32'hF0, 1'b1, 1'b0);
    lookup("bwd", 32'h100, 1'b1, 1'b1, 32'hF0);

    // Misaligned target from a hit, taken: reject and entry dropped
    update("misalign", 32'h10, 32'h12, 1'b1, 1'b1);
    idle_rej_clear("misalign");
    lookup("misalign_lk", 32'h10, 1'b0, 1'b0, 32'd0);

    // Range edges
    update("diff_20000", 32'h0, 32'h0002_0004, 1'b1, 1'b1);
    lookup("diff_20000_lk", 32'h0, 1'b0, 1'b0, 32'd0);
    update("diff_1fffc", 32'h0, 32'h0002_0000, 1'b1, 1'b0);
    lookup("diff_1fffc_lk", 32'h0, 1'b1, 1'b1, 32'h0002_0000);
    lookup("idx0_replaced", 32'h100, 1'b0, 1'b0, 32'd0);

    // Counter saturation; not-taken updates must not move the offset
    update("sat_alloc", 32'h10, 32'h30, 1'b1, 1'b0);
    update("sat_nt1", 32'h10, 32'h40, 1'b0, 1'b0);
    lookup("sat_01", 32'h10, 1'b1, 1'b0, 32'h30);
    update("sat_nt2", 32'h10, 32'h40, 1'b0, 1'b0);
    update("sat_nt3", 32'h10, 32'h40, 1'b0, 1'b0);
    lookup("sat_00", 32'h10, 1'b1, 1'b0, 32'h30);
    update("sat_t1", 32'h10, 32'h30, 1'b1, 1'b0);
    lookup("sat_back01", 32'h10, 1'b1, 1'b0, 32'h30);
    update("sat_t2", 32'h10, 32'h30, 1'b1, 1'b0);
    lookup("sat_10", 32'h10, 1'b1, 1'b1, 32'h30);

    // Aliasing on idx 4
    lookup("alias_miss", 32'h50, 1'b0, 1'b0, 32'd0);
    update("alias_upd", 32'h50, 32'h60, 1'b1, 1'b0);
    lookup("alias_hit", 32'h50, 1'b1, 1'b1, 32'h60);
    lookup("alias_old", 32'h10, 1'b0, 1'b0, 32'd0);

    // Same-index lookup and update: lookup sees pre-edge contents
    @(negedge clk);
    bus.if_pc     = 32'h10;
    bus.upd_en    = 1'b1;
    bus.upd_pc    = 32'h10;
    bus.upd_dest  = 32'h30;
    bus.upd_taken = 1'b1;
    push_lookup("nowt_pre", 1'b0, 1'b0, 32'd0);
    sb_push("nowt_rej", 32'd0);
    #2;
    pop_lookup();
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
    sb_pop({31'd0, bus.upd_reject});
    push_lookup("nowt_post", 1'b1, 1'b1, 32'h30);
    pop_lookup();

    // 32-bit wrap-around of both encode and rebuild
    update("wrap", 32'hFFFF_FFF0, 32'h0000_0004, 1'b1, 1'b0);
    lookup("wrap_lk", 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h0000_0004);

    // Async reset during an update, with upd_reject high
    update("pre_rst_rej", 32'h20, 32'h0010_0000, 1'b0, 1'b1);
    bus.upd_en    = 1'b1;
    bus.upd_pc    = 32'h20;
    bus.upd_dest  = 32'h40;
    bus.upd_taken = 1'b1;
    bus.if_pc     = 32'h50;
    #2;
    rst = 1'b1;
    #1;
    push_lookup("rst_mid", 1'b0, 1'b0, 32'd0);
    sb_push("rst_mid_rej", 32'd0);
    pop_lookup();
    sb_pop({31'd0, bus.upd_reject});
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    bus.upd_en = 1'b0;
    lookup("rst_wrap_gone", 32'hFFFF_FFF0, 1'b0, 1'b0, 32'd0);
    lookup("rst_discard", 32'h20, 1'b0, 1'b0, 32'd0);

`ifdef BTB_FLUSH_EN
    update("fl_alloc", 32'h10, 32'h30, 1'b1, 1'b0);
    @(negedge clk);
    bus.btb_flush = 1'b1;
    update("fl_rej", 32'h20, 32'h22, 1'b1, 1'b1);
    lookup("fl_lk", 32'h10, 1'b0, 1'b0, 32'd0);
    update("fl_enc", 32'h20, 32'h40, 1'b1, 1'b0);
    bus.btb_flush = 1'b0;
    lookup("fl_lk2", 32'h20, 1'b0, 1'b0, 32'd0);
`endif

    if (sb_q.size() != 0) chk_val("sb_leftover", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btb_offset_enc.md
Name: btb_offset_enc

Overview:
- Direct-mapped branch target buffer for the pipelined MIPS CPU.
- On the ID-stage update path it takes a resolved branch's target address and re-encodes it into the 16-bit word offset relative to PC+4. This is the inverse of the beq/bne target adder.
- On the IF-stage lookup path it stores the offset with a 2-bit direction counter and rebuilds the predicted target.
- The offset is stored instead of the 32-bit target to save storage.

Parameters:
- ENTRIES, 16, number of buffer entries; must be a power of 2.
- IDX_W, 4, index width; equals log2(ENTRIES).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_pc  input  32  IF-stage PC to look up (word aligned).
- pred_hit  output  1  valid entry with matching tag for if_pc.
- pred_taken  output  1  pred_hit AND counter[1].
- pred_dest  output  32  if_pc + 4 + {{14{off[15]}}, off, 2'b0}; 0 when no hit.
- upd_en  input  1  ID stage resolved a beq/bne this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual branch outcome.
- upd_dest  input  32  actual branch target address.
- upd_reject  output  1  registered; target not encodable as a 16-bit offset.
- btb_flush  input  1  only present with BTB_FLUSH_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - All valid bits 0; counters 2'b01; tags and offsets 0.
  - upd_reject 0.
  - Lookup outputs are combinational, so they read 0 while in reset.
- Addressing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] && tag[idx] == if_pc tag.
  - pred_dest is computed with 32-bit wrap-around addition.
- Encoding on update:
  - diff = upd_dest - (upd_pc + 4), 32-bit modular.
  - Encodable iff diff[1:0] == 0 and diff[31:17] is all copies of diff[17], i.e. range -0x20000..+0x1FFFC.
  - off = diff[17:2].
- Update, applied at the rising edge when upd_en = 1:
  - Encodable, tag hit:
    - counter +1 if taken, saturating at 11; -1 if not taken, saturating at 00.
    - Offset is overwritten only if taken.
  - Encodable, miss, taken: allocate/replace the entry with valid = 1, the new tag, off, counter = 2'b10.
  - Encodable, miss, not taken: no change.
  - Not encodable:
    - No state change.
    - On a tag hit with taken, the entry is invalidated, because its stored target is now wrong.
    - upd_reject = 1 in the next cycle, for exactly one cycle.
  - upd_reject = 0 whenever the previous cycle had upd_en = 0 or an encodable update.
- Simultaneous lookup and update on the same index: lookup sees the pre-edge contents. There is no write-through.
- Reset mid-update: the write is discarded; state returns to the reset values immediately.

Optional Feature:
- Macro: BTB_FLUSH_EN.
- Defined:
  - btb_flush port exists.
  - btb_flush = 1 at a clock edge synchronously clears all valid bits; counters are kept.
  - Flush has priority over a simultaneous upd_en; upd_reject is still computed from that update.
- Not defined: no btb_flush port; valid bits are cleared only by rst.

Test Plan:
- Allocate forward:
  - upd_en, upd_pc=0x00000010, upd_dest=0x00000030, taken → upd_reject=0.
  - Next cycle if_pc=0x10 → pred_hit=1, pred_taken=1, pred_dest=0x00000030 (stored off=0x0007).
- Backward target: upd_pc=0x00000100, upd_dest=0x000000F0, taken → off=0xFFFB; lookup 0x100 → pred_dest=0x000000F0.
- Rejects:
  - upd_dest=0x00000012 from pc 0x10 (misaligned) → upd_reject=1 for one cycle, lookup still misses.
  - upd_pc=0x0, upd_dest=0x00020004 (diff 0x20000) → reject.
  - upd_pc=0x0, upd_dest=0x00020000 (diff 0x1FFFC) → accepted, off=0x7FFF.
- Counter saturation: after allocating at pc 0x10, three not-taken updates → counter 10→01→00→00; pred_taken=0 after the first, pred_hit stays 1.
- Aliasing: allocate pc 0x10, then lookup 0x50 (same idx 4, different tag) → pred_hit=0; a taken update at 0x50 replaces the entry, and lookup 0x10 then misses.
- Reset and flush:
  - Assert rst asynchronously mid-update → all lookups miss and upd_reject=0 immediately.
  - With BTB_FLUSH_EN, btb_flush together with upd_en → all entries invalid next cycle.
